// File: rtl/tempsense_sweep_ctrl.sv
// Temperature-sensor sweep controller: steps the DAC code down from all-ones until the delay line flips.
// Optional latched alarm comparator enabled by TEMPSENSE_CTRL_ALARM_EN; each step takes i_settle+4 cycles.
module tempsense_sweep_ctrl #(
   parameter int N_VDAC = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_auto,
   input  logic [3:0]        i_settle,
   input  logic              i_temp_delay,
`ifdef TEMPSENSE_CTRL_ALARM_EN
   input  logic [N_VDAC-1:0] i_alarm_thr,
   input  logic              i_alarm_clr,
`endif
   output logic [N_VDAC-1:0] o_dac_data,
   output logic              o_dac_en,
   output logic              o_precharge_n,
   output logic              o_busy,
   output logic              o_valid,
   output logic [N_VDAC-1:0] o_result,
   output logic              o_nohit,
   output logic              o_alarm
);

   typedef enum logic [2:0] {
      IDLE, PRECHARGE, TRANSITION, MEASURE, EVALUATE, DONE
   } state_t;

   localparam logic [N_VDAC-1:0] CODE_MAX = '1;

   state_t            state, state_n;
   logic [N_VDAC-1:0] code;
   logic              last;
   logic [3:0]        settle_cnt;
   logic              step_start;
   logic              sweep_start;
   logic              hit;

   // A hit needs a 0->1 flip of the delay line, so the first step can never hit.
   assign hit = !last && i_temp_delay;

   always_comb begin
      state_n     = state;
      step_start  = 1'b0;
      sweep_start = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_n     = PRECHARGE;
               step_start  = 1'b1;
               sweep_start = 1'b1;
            end
         end
         PRECHARGE:  state_n = TRANSITION;
         TRANSITION: state_n = MEASURE;
         MEASURE: begin
            if (settle_cnt == 4'd0) state_n = EVALUATE;
         end
         EVALUATE: begin
            if (hit || code == '0) begin
               state_n = DONE;
            end else begin
               state_n    = PRECHARGE;
               step_start = 1'b1;
            end
         end
         DONE: begin
            if (i_auto) begin
               state_n     = PRECHARGE;
               step_start  = 1'b1;
               sweep_start = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         code       <= CODE_MAX;
         last       <= 1'b1;
         settle_cnt <= 4'd0;
         o_result   <= '0;
         o_nohit    <= 1'b0;
      end else begin
         state <= state_n;
         // Settle length is frozen at the start of every step.
         if (step_start)
            settle_cnt <= i_settle;
         else if (state == MEASURE && settle_cnt != 4'd0)
            settle_cnt <= settle_cnt - 4'd1;
         if (sweep_start) begin
            code <= CODE_MAX;
            last <= 1'b1;
         end else if (state == EVALUATE) begin
            last <= i_temp_delay;
            if (hit) begin
               o_result <= code;
               o_nohit  <= 1'b0;
            end else if (code == '0) begin
               o_nohit <= 1'b1;
            end else begin
               code <= code - N_VDAC'(1);
            end
         end
      end
   end

   always_comb begin
      o_dac_data    = CODE_MAX;
      o_precharge_n = 1'b0;
      case (state)
         TRANSITION: begin
            o_dac_data    = '0;
            o_precharge_n = 1'b1;
         end
         MEASURE, EVALUATE: begin
            o_dac_data    = code;
            o_precharge_n = 1'b1;
         end
         DONE:    o_dac_data = code;
         default: o_dac_data = CODE_MAX;
      endcase
   end

   assign o_dac_en = (state != IDLE);
   assign o_busy   = (state != IDLE);
   assign o_valid  = (state == DONE);

`ifdef TEMPSENSE_CTRL_ALARM_EN
   always_ff @(posedge clk) begin
      if (reset)
         o_alarm <= 1'b0;
      else if (state == DONE && !o_nohit && o_result < i_alarm_thr)
         o_alarm <= 1'b1;
      else if (i_alarm_clr)
         o_alarm <= 1'b0;
   end
`else
   assign o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_tempsense_sweep_ctrl.sv
// Directed bench for tempsense_sweep_ctrl: table of full sweeps plus hand sequences for
// settle capture, auto mode, mid-sweep reset and (when TEMPSENSE_CTRL_ALARM_EN is set) the alarm latch.
module tb_tempsense_sweep_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       i_start;
   logic       i_auto;
   logic [3:0] i_settle;
   logic       i_temp_delay;
   logic [5:0] i_alarm_thr;
   logic       i_alarm_clr;
   logic [5:0] o_dac_data;
   logic       o_dac_en;
   logic       o_precharge_n;
   logic       o_busy;
   logic       o_valid;
   logic [5:0] o_result;
   logic       o_nohit;
   logic       o_alarm;

   int checks   = 0;
   int failures = 0;
   int model_thr = -1;
   int cyc;
   int lat;
   int vcount;

   typedef struct {
      int thr;
      int settle;
      int lat;
      int result;
      int nohit;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   // Sensor model: delay line reads 1 once the applied code is at or below model_thr (-1 = never).
   always_comb i_temp_delay = (model_thr >= 0) && (int'(o_dac_data) <= model_thr);

   tempsense_sweep_ctrl #(.N_VDAC(6)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_start       (i_start),
      .i_auto        (i_auto),
      .i_settle      (i_settle),
      .i_temp_delay  (i_temp_delay),
`ifdef TEMPSENSE_CTRL_ALARM_EN
      .i_alarm_thr   (i_alarm_thr),
      .i_alarm_clr   (i_alarm_clr),
`endif
      .o_dac_data    (o_dac_data),
      .o_dac_en      (o_dac_en),
      .o_precharge_n (o_precharge_n),
      .o_busy        (o_busy),
      .o_valid       (o_valid),
      .o_result      (o_result),
      .o_nohit       (o_nohit),
      .o_alarm       (o_alarm)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Waits (bounded) for o_valid; leaves the bench in the DONE cycle.
   task automatic wait_valid(input string name, input int exp_cyc);
      while (!o_valid && cyc < 3000) step();
      check(name, cyc, exp_cyc);
   endtask

   // Pulses i_start in the idle cycle numbered 0 and checks the first two step states.
   task automatic start_sweep();
      i_start = 1'b1;
      cyc = 0;
      step();
      i_start = 1'b0;
      check("prech_dac", int'(o_dac_data), 63);
      check("prech_n", int'(o_precharge_n), 0);
      check("prech_en_busy", int'({o_dac_en, o_busy}), 3);
      step();
      check("trans_dac_pn", int'({o_dac_data, o_precharge_n}), 1);
   endtask

   initial begin
      vecs[0] = '{thr: 40, settle: 0, lat: 97,  result: 40, nohit: 0};
      vecs[1] = '{thr: 40, settle: 3, lat: 169, result: 40, nohit: 0};
      vecs[2] = '{thr: 62, settle: 0, lat: 9,   result: 62, nohit: 0};
      vecs[3] = '{thr: 63, settle: 0, lat: 257, result: 62, nohit: 1};
      vecs[4] = '{thr: -1, settle: 1, lat: 321, result: 62, nohit: 1};
      vecs[5] = '{thr: 0,  settle: 0, lat: 257, result: 0,  nohit: 0};

      reset = 1'b1; i_start = 1'b0; i_auto = 1'b0; i_settle = 4'd0;
      i_alarm_thr = 6'd0; i_alarm_clr = 1'b0;
      cyc = 0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check("rst_busy", int'(o_busy), 0);
      check("rst_valid", int'(o_valid), 0);
      check("rst_result", int'(o_result), 0);
      check("rst_nohit", int'(o_nohit), 0);
      check("rst_alarm", int'(o_alarm), 0);
      check("idle_outs", int'({o_dac_data, o_dac_en, o_precharge_n}), 63 << 2);

      for (int i = 0; i < 6; i++) begin
         model_thr = vecs[i].thr;
         i_settle  = 4'(vecs[i].settle);
         start_sweep();
         wait_valid($sformatf("v%0d_latency", i), vecs[i].lat);
         check($sformatf("v%0d_result", i), int'(o_result), vecs[i].result);
         check($sformatf("v%0d_nohit", i), int'(o_nohit), vecs[i].nohit);
         step();
         check($sformatf("v%0d_idle", i), int'({o_busy, o_valid}), 0);
      end

      // Mid-step settle change: first step keeps 3 settle cycles, the rest use 0.
      model_thr = 40;
      i_settle  = 4'd3;
      start_sweep();
      step();
      i_settle = 4'd0;
      repeat (4) step();
      check("settle_eval_dac", int'({o_dac_data, o_precharge_n}), (63 << 1) | 1);
      step();
      check("settle_next_prech", int'({o_dac_data, o_precharge_n}), 63 << 1);
      wait_valid("settle_latency", 100);
      check("settle_result", int'(o_result), 40);

      // Auto mode: back-to-back sweeps, busy start ignored, dropping auto ends after DONE.
      step();
      model_thr = 62;
      i_auto = 1'b1;
      start_sweep();
      wait_valid("auto_first", 9);
      step();
      check("auto_restart", int'({o_busy, o_dac_data, o_precharge_n}), (1 << 7) | (63 << 1));
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      i_auto  = 1'b0;
      wait_valid("auto_second", 18);
      check("auto_result", int'(o_result), 62);
      step();
      check("auto_to_idle", int'(o_busy), 0);
      repeat (3) step();
      check("start_not_queued", int'(o_busy), 0);

      // Reset during MEASURE aborts with no valid.
      i_settle = 4'd3;
      model_thr = 40;
      start_sweep();
      repeat (2) step();
      reset = 1'b1;
      step();
      check("mrst_status", int'({o_busy, o_valid, o_dac_en, o_precharge_n, o_nohit, o_alarm}), 0);
      check("mrst_result", int'(o_result), 0);
      reset = 1'b0;
      vcount = 0;
      repeat (400) begin
         step();
         if (o_valid) vcount++;
      end
      check("mrst_no_valid", vcount, 0);

`ifdef TEMPSENSE_CTRL_ALARM_EN
      i_settle = 4'd0;
      i_alarm_thr = 6'd45;
      start_sweep();
      wait_valid("alarm_sweep", 97);
      step();
      check("alarm_set", int'(o_alarm), 1);
      repeat (5) step();
      check("alarm_hold", int'(o_alarm), 1);
      i_alarm_clr = 1'b1;
      start_sweep();
      wait_valid("alarm_sweep2", 97);
      step();
      check("alarm_set_wins", int'(o_alarm), 1);
      step();
      check("alarm_cleared", int'(o_alarm), 0);
      i_alarm_clr = 1'b0;
`else
      i_settle = 4'd0;
      start_sweep();
      wait_valid("noalarm_sweep", 97);
      step();
      check("alarm_tied_low", int'(o_alarm), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tempsense_sweep_ctrl.md
TEMPSENSE_SWEEP_CTRL -- requirements
Module: tempsense_sweep_ctrl

Interface
REQ-001 Parameter N_VDAC, default 6, sets the DAC code width and the result width.
REQ-002 clk  input  1  single clock; every register is clocked on its rising edge.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_start  input  1  conversion request; sampled only in IDLE.
REQ-006 i_auto  input  1  continuous mode; a new sweep starts after each DONE.
REQ-007 i_settle  input  4  extra MEASURE cycles per DAC step.
REQ-008 i_temp_delay  input  1  delay-line output from the sensor core.
REQ-009 o_dac_data  output  N_VDAC  DAC code to the sensor.
REQ-010 o_dac_en  output  1  sensor enable.
REQ-011 o_precharge_n  output  1  precharge control; 0 means precharge.
REQ-012 o_busy  output  1  high in every state except IDLE.
REQ-013 o_valid  output  1  one-cycle pulse in DONE.
REQ-014 o_result  output  N_VDAC  last converted DAC code; held until the next DONE.
REQ-015 o_nohit  output  1  the last sweep ended without a transition; updated in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, PRECHARGE, TRANSITION, MEASURE, EVALUATE and DONE; all outputs SHALL be registered or decoded from the state only.
REQ-017 IDLE SHALL drive dac_en=0, dac_data=all-ones and precharge_n=0; on i_start=1 it SHALL go to PRECHARGE, load code=all-ones and set last=1.
REQ-018 PRECHARGE SHALL last 1 cycle with dac_en=1, dac_data=all-ones and precharge_n=0, then go to TRANSITION.
REQ-019 TRANSITION SHALL last 1 cycle with dac_data=0 and precharge_n=1, then go to MEASURE.
REQ-020 MEASURE SHALL last i_settle+1 cycles with dac_data=code and precharge_n=1; i_settle SHALL be captured at each step start, so a mid-step change has no effect.
REQ-021 EVALUATE SHALL last 1 cycle with dac_data=code and precharge_n=1.
REQ-022 EVALUATE SHALL record a hit when last=0 and i_temp_delay=1; it SHALL then set last=i_temp_delay.
REQ-023 Each DAC step SHALL take i_settle+4 cycles.
REQ-024 On a hit, the next state SHALL be DONE with result=code and nohit=0.
REQ-025 With no hit and code=0, the next state SHALL be DONE with result unchanged and nohit=1; code SHALL never wrap.
REQ-026 With no hit and code>0, code SHALL decrement by 1 and the next state SHALL be PRECHARGE.
REQ-027 DONE SHALL last 1 cycle with o_valid=1, then go to PRECHARGE (code reloaded, last=1) if i_auto=1, else to IDLE.
REQ-028 i_start while busy SHALL be ignored and never queued.
REQ-029 Clearing i_auto mid-sweep SHALL let the current sweep finish and then return to IDLE.

Reset
REQ-030 Reset SHALL force IDLE, code=all-ones and last=1.
REQ-031 Reset SHALL clear o_result, o_valid, o_busy, o_nohit and o_alarm to 0.
REQ-032 Reset SHALL take priority over every other event, including a reset asserted mid-sweep; no o_valid SHALL be produced for an aborted sweep.

Configuration
REQ-033 Macro TEMPSENSE_CTRL_ALARM_EN, when defined, SHALL add input i_alarm_thr [N_VDAC-1:0] and input i_alarm_clr [1].
REQ-034 With TEMPSENSE_CTRL_ALARM_EN defined, o_alarm SHALL set in the cycle after a DONE with nohit=0 and result < i_alarm_thr.
REQ-035 With TEMPSENSE_CTRL_ALARM_EN defined, o_alarm SHALL stay set until i_alarm_clr=1; if set and clear occur together, set SHALL win.
REQ-036 Without TEMPSENSE_CTRL_ALARM_EN, the alarm ports SHALL be absent and o_alarm SHALL be tied to 0.

Verification
REQ-037 Sensor model returns 1 when code<=40; i_settle=0; i_start pulsed at cycle 0 -> EVALUATE at code 40 in cycle 96, o_valid in cycle 97, o_result=40, o_nohit=0, then IDLE.
REQ-038 Sensor model always 0 -> 64 steps, o_valid with o_nohit=1, o_result keeps its prior value, and o_dac_data never goes below 0 or wraps.
REQ-039 i_settle=3, sensor model as REQ-037 -> every step lasts 7 cycles and MEASURE is 4 cycles; a change to i_settle mid-step has no effect until the next step.
REQ-040 i_auto=1 -> DONE is followed directly by PRECHARGE with o_dac_data=63; i_start pulses while busy are ignored; dropping i_auto gives IDLE after the current DONE.
REQ-041 Reset asserted during MEASURE -> next cycle IDLE with all outputs 0 and no o_valid.
REQ-042 With TEMPSENSE_CTRL_ALARM_EN, thr=45, result=40 -> o_alarm=1 and it holds; i_alarm_clr coinciding with a new set event -> o_alarm stays 1.
